// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial WIDTH-bit subtractor computing a - b, LSB first, one bit per
// clock through a single full-subtractor cell (two half-subtractor stages plus an OR) with a
// registered borrow.
//
// Optional feature macro: SERIAL_SUB_OVF_EN
//   defined   -> overflow is the registered signed-overflow flag of the last result
//   undefined -> overflow is tied to 0 and no operand-MSB capture registers exist
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   start      request, sampled only while idle
//   a, b       minuend / subtrahend, captured on the accepting edge
//   busy       high while a subtraction is in progress
//   done       one-cycle pulse when diff/borrow_out/overflow update
//   diff       (a - b) mod 2^WIDTH, held until the next completion
//   borrow_out final borrow (a < b unsigned), held until the next completion
//   overflow   signed overflow of the last result (0 when the feature is disabled)

module serial_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             overflow
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  // Holds the WIDTH-1 bits already produced; the final bit completes the result.
  logic [WIDTH-2:0] res_q, res_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             br_q, br_d;
  logic             borrow_q, borrow_d;
  logic             done_q, done_d;
  logic [CntW-1:0]  cnt_q, cnt_d, cnt_inc;
  logic             last;

  // Full-subtractor cell built from two half-subtractors.
  logic a0, b0, hs1_d, hs1_b, hs2_b, d_bit, br_next;
  logic [WIDTH-1:0] res_next;

  assign a0      = a_q[0];
  assign b0      = b_q[0];
  assign hs1_d   = a0 ^ b0;
  assign hs1_b   = ~a0 & b0;
  assign d_bit   = hs1_d ^ br_q;
  assign hs2_b   = ~hs1_d & br_q;
  assign br_next = hs1_b | hs2_b;

  assign res_next = {d_bit, res_q};
  assign cnt_inc  = cnt_q + CntW'(1);
  assign last     = (cnt_inc == CntW'(WIDTH));

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    diff_d   = diff_q;
    br_d     = br_q;
    borrow_d = borrow_q;
    done_d   = 1'b0;
    cnt_d    = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          res_d   = '0;
          br_d    = 1'b0;
          cnt_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        a_d   = {1'b0, a_q[WIDTH-1:1]};
        b_d   = {1'b0, b_q[WIDTH-1:1]};
        res_d = res_next[WIDTH-1:1];
        br_d  = br_next;
        cnt_d = cnt_inc;
        if (last) begin
          diff_d   = res_next;
          borrow_d = br_next;
          done_d   = 1'b1;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      diff_q   <= '0;
      br_q     <= 1'b0;
      borrow_q <= 1'b0;
      done_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      diff_q   <= diff_d;
      br_q     <= br_d;
      borrow_q <= borrow_d;
      done_q   <= done_d;
      cnt_q    <= cnt_d;
    end
  end

`ifdef SERIAL_SUB_OVF_EN
  // Operand MSBs are kept separately because the shift registers lose them during RUN.
  logic amsb_q, amsb_d, bmsb_q, bmsb_d, ovf_q, ovf_d;

  always_comb begin
    amsb_d = amsb_q;
    bmsb_d = bmsb_q;
    ovf_d  = ovf_q;
    if (state_q == StIdle && start) begin
      amsb_d = a[WIDTH-1];
      bmsb_d = b[WIDTH-1];
    end
    if (state_q == StRun && last) begin
      // d_bit is the result MSB on the final cycle.
      ovf_d = (amsb_q ^ bmsb_q) & (d_bit ^ amsb_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      amsb_q <= 1'b0;
      bmsb_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      amsb_q <= amsb_d;
      bmsb_q <= bmsb_d;
      ovf_q  <= ovf_d;
    end
  end

  assign overflow = ovf_q;
`else
  assign overflow = 1'b0;
`endif

  assign busy       = (state_q == StRun);
  assign done       = done_q;
  assign diff       = diff_q;
  assign borrow_out = borrow_q;

endmodule
